// File: rtl/led_ctrl_pkg.sv
// LED controller shared definitions.
// Register offsets, reset values and channel modes.
package led_ctrl_pkg;

  localparam logic [7:0] OFF_LED_OUT = 8'h00;
  localparam logic [7:0] OFF_LED_SET = 8'h04;
  localparam logic [7:0] OFF_LED_CLR = 8'h08;
  localparam logic [7:0] OFF_LED_TGL = 8'h0C;
  localparam logic [7:0] OFF_MODE    = 8'h10;
  localparam logic [7:0] OFF_BLINK   = 8'h14;
  localparam logic [7:0] OFF_STATUS  = 8'h18;
  localparam logic [7:0] OFF_DUTY0   = 8'h20;

  localparam int unsigned BLINK_RST = 12_500_000;

  typedef enum logic {
    LED_STATIC = 1'b0,
    LED_BLINK  = 1'b1
  } led_mode_e;

  function automatic logic [5:0] word_of(
    input logic [7:0] off
  );
    return off[7:2];
  endfunction

endpackage

// File: rtl/led_ctrl_mm_timebase.sv
// PWM prescaler/counter and blink phase generator.
// Shared by all LED channels.
module led_timebase
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PWM_PRESCALE = 16,
  parameter int BLINK_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BLINK_W-1:0]  blink_period,
  input  logic                blink_clr,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blink_phase,
  output logic                pwm_wrap
);

  localparam int PS_W =
    (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [PS_W-1:0]    presc;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_lim;
  logic               presc_wrap;

  assign presc_wrap = (presc == PS_W'(PWM_PRESCALE - 1));
  assign pwm_wrap   = (pwm_cnt == '0);

  // A zero period behaves like one: toggle every cycle.
  assign blink_lim = (blink_period == '0) ? '0
                                          : blink_period - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (presc_wrap) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_clr) begin
      blink_cnt   <= '0;
    end else if (blink_cnt >= blink_lim) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_ctrl_mm.sv
// Memory-mapped LED controller on the shared peripheral bus.
// Register file, per-channel PWM/blink gating, tri-state bus reply.
module led_ctrl_mm
  import led_ctrl_pkg::*;
#(
  parameter int          NUM_LEDS     = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          PWM_BITS     = 8,
  parameter int          PWM_PRESCALE = 16,
  parameter int          BLINK_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_LEDS-1:0] LEDR,
  input  logic                write_i,
  input  logic                read_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  inout  tri   [31:0]         data_o,
  inout  tri                  ack_o
);

  logic [NUM_LEDS-1:0] led_out;
  logic [NUM_LEDS-1:0] mode;
  logic [BLINK_W-1:0]  blink;
  logic [PWM_BITS-1:0] duty [NUM_LEDS];
  logic [NUM_LEDS-1:0] pwm_on;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_phase;
  logic                pwm_wrap;
  logic [31:0]         rdata;

  logic       cs, wr, rd;
  logic [5:0] widx, didx;
  logic       sel_out, sel_set, sel_clr, sel_tgl;
  logic       sel_mode, sel_blink, sel_stat, sel_duty;

  logic unused_ok;
  assign unused_ok = &{1'b0, addr_i[1:0], data_i};

  assign cs   = (addr_i[31:8] == BASE_ADDR[31:8]);
  assign wr   = cs & write_i;
  assign rd   = cs & read_i;
  assign widx = addr_i[7:2];
  assign didx = widx - word_of(OFF_DUTY0);

  assign sel_out   = (widx == word_of(OFF_LED_OUT));
  assign sel_set   = (widx == word_of(OFF_LED_SET));
  assign sel_clr   = (widx == word_of(OFF_LED_CLR));
  assign sel_tgl   = (widx == word_of(OFF_LED_TGL));
  assign sel_mode  = (widx == word_of(OFF_MODE));
  assign sel_blink = (widx == word_of(OFF_BLINK));
  assign sel_stat  = (widx == word_of(OFF_STATUS));
  assign sel_duty  = (widx >= word_of(OFF_DUTY0))
                   & (int'(didx) < NUM_LEDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
      mode    <= '0;
      blink   <= BLINK_W'(BLINK_RST);
      for (int i = 0; i < NUM_LEDS; i++)
        duty[i] <= '1;
    end else if (wr) begin
      unique case (1'b1)
        sel_out:   led_out <= data_i[NUM_LEDS-1:0];
        sel_set:   led_out <= led_out | data_i[NUM_LEDS-1:0];
        sel_clr:   led_out <= led_out & ~data_i[NUM_LEDS-1:0];
        sel_tgl:   led_out <= led_out ^ data_i[NUM_LEDS-1:0];
        sel_mode:  mode    <= data_i[NUM_LEDS-1:0];
        sel_blink: blink   <= data_i[BLINK_W-1:0];
        sel_duty:
          for (int i = 0; i < NUM_LEDS; i++)
            if (didx == 6'(i))
              duty[i] <= data_i[PWM_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Read data reflects registers before any same-cycle write.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_out, sel_set,
      sel_clr, sel_tgl: rdata = 32'(led_out);
      sel_mode:  rdata = 32'(mode);
      sel_blink: rdata = 32'(blink);
      sel_stat:  rdata = {30'b0, pwm_wrap, blink_phase};
      sel_duty:
        for (int i = 0; i < NUM_LEDS; i++)
          if (didx == 6'(i))
            rdata = 32'(duty[i]);
      default: ;
    endcase
  end

  assign data_o = rd ? rdata : 'z;
  assign ack_o  = (cs & (read_i | write_i)) ? 1'b1 : 1'bz;

  led_timebase #(
    .PWM_BITS     (PWM_BITS),
    .PWM_PRESCALE (PWM_PRESCALE),
    .BLINK_W      (BLINK_W)
  ) u_tb (
    .clk          (clk),
    .rst          (rst),
    .blink_period (blink),
    .blink_clr    (wr & sel_blink),
    .pwm_cnt      (pwm_cnt),
    .blink_phase  (blink_phase),
    .pwm_wrap     (pwm_wrap)
  );

  always_comb begin
    pwm_on = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      pwm_on[i] = (duty[i] == '1) | (pwm_cnt < duty[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LEDR <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        LEDR[i] <= led_out[i] & pwm_on[i]
                 & ((mode[i] == 1'(LED_BLINK)) ? blink_phase
                                                : 1'b1);
    end
  end

endmodule

// File: tb/tb_led_ctrl_mm.sv
// Directed self-checking bench for led_ctrl_mm.
// Prescale 1 so one PWM period is 256 clocks.
module tb_led_ctrl_mm;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_i = 1'b0;
  logic        read_i = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  wire  [31:0] data_w;
  wire         ack_w;
  logic [9:0]  ledr;

  int tests = 0;
  int fails = 0;

  led_ctrl_mm #(
    .NUM_LEDS     (10),
    .BASE_ADDR    (BASE),
    .PWM_BITS     (8),
    .PWM_PRESCALE (1),
    .BLINK_W      (24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .LEDR    (ledr),
    .write_i (write_i),
    .read_i  (read_i),
    .addr_i  (addr),
    .data_i  (wdat),
    .data_o  (data_w),
    .ack_o   (ack_w)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    addr = a; wdat = d; write_i = 1'b1;
    @(negedge clk);
    write_i = 1'b0;
  endtask

  task automatic bus_read(input  logic [31:0] a,
                          output logic [31:0] d,
                          output logic        ak);
    @(negedge clk);
    addr = a; read_i = 1'b1;
    #1;
    d = data_w; ak = ack_w;
    read_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic ak;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ledr !== 10'h000) begin
      fails++;
      $display("FAIL rst_ledr got %h exp 000", ledr);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(BASE + 32'h00, d, ak);
    tests++;
    if (d !== 32'h0 || ak !== 1'b1) begin
      fails++;
      $display("FAIL rst_out got %h/%b exp 0/1", d, ak);
    end
    bus_read(BASE + 32'h20, d, ak);
    tests++;
    if (d !== 32'hFF) begin
      fails++;
      $display("FAIL rst_duty got %h exp ff", d);
    end
    bus_read(BASE + 32'h14, d, ak);
    tests++;
    if (d !== 32'd12_500_000) begin
      fails++;
      $display("FAIL rst_blink got %0d exp 12500000", d);
    end
    @(negedge clk);
    addr = 32'h1234_0000;
    #1;
    tests++;
    if (ack_w === 1'b1) begin
      fails++;
      $display("FAIL idle_ack got %b exp z", ack_w);
    end
  endtask

  task automatic test_static_on();
    bus_write(BASE + 32'h00, 32'h3FF);
    #1;
    tests++;
    if (ledr !== 10'h000) begin
      fails++;
      $display("FAIL ledr_latency got %h exp 000", ledr);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ledr !== 10'h3FF) begin
      fails++;
      $display("FAIL ledr_on got %h exp 3ff", ledr);
    end
  endtask

  task automatic test_set_clr_tgl();
    logic [31:0] d;
    logic ak;
    bus_write(BASE + 32'h00, 32'h0F0);
    bus_write(BASE + 32'h04, 32'h00F);
    bus_read(BASE + 32'h04, d, ak);
    tests++;
    if (d !== 32'h0FF) begin
      fails++;
      $display("FAIL led_set got %h exp 0ff", d);
    end
    bus_write(BASE + 32'h08, 32'h030);
    bus_read(BASE + 32'h08, d, ak);
    tests++;
    if (d !== 32'h0CF) begin
      fails++;
      $display("FAIL led_clr got %h exp 0cf", d);
    end
    bus_write(BASE + 32'h0C, 32'h101);
    bus_read(BASE + 32'h00, d, ak);
    tests++;
    if (d !== 32'h1CE) begin
      fails++;
      $display("FAIL led_tgl got %h exp 1ce", d);
    end
  endtask

  task automatic test_read_write_same();
    logic [31:0] d;
    logic ak;
    bus_write(BASE + 32'h00, 32'h0AA);
    @(negedge clk);
    addr = BASE; wdat = 32'h055;
    write_i = 1'b1; read_i = 1'b1;
    #1;
    d = data_w;
    @(negedge clk);
    write_i = 1'b0; read_i = 1'b0;
    tests++;
    if (d !== 32'h0AA) begin
      fails++;
      $display("FAIL rw_pre got %h exp 0aa", d);
    end
    bus_read(BASE, d, ak);
    tests++;
    if (d !== 32'h055) begin
      fails++;
      $display("FAIL rw_post got %h exp 055", d);
    end
  endtask

  task automatic test_blink();
    logic prev;
    int   last, ntr, bad, badgap;
    bus_write(BASE + 32'h10, 32'h001);
    bus_write(BASE + 32'h00, 32'h003);
    bus_write(BASE + 32'h14, 32'd4);
    @(posedge clk);
    #1;
    prev = ledr[0];
    last = -1; ntr = 0; bad = 0; badgap = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ledr[9:1] !== 9'h001) bad++;
      if (ledr[0] !== prev) begin
        if (last >= 0 && c - last != 4) badgap = c - last;
        last = c;
        ntr++;
        prev = ledr[0];
      end
    end
    tests++;
    if (ntr < 9 || badgap != 0) begin
      fails++;
      $display("FAIL blink_period got %0d edges gap %0d exp 4",
               ntr, badgap);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL blink_others got %0d bad exp 0", bad);
    end
  endtask

  task automatic test_pwm();
    logic [31:0] d;
    logic ak;
    int   on0, on1;
    bus_write(BASE + 32'h10, 32'h000);
    bus_write(BASE + 32'h00, 32'h003);
    bus_write(BASE + 32'h20, 32'h040);
    bus_read(BASE + 32'h20, d, ak);
    tests++;
    if (d !== 32'h40) begin
      fails++;
      $display("FAIL duty_rd got %h exp 40", d);
    end
    repeat (2) @(posedge clk);
    on0 = 0; on1 = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk);
      #1;
      if (ledr[0] === 1'b1) on0++;
      if (ledr[1] === 1'b1) on1++;
    end
    tests++;
    if (on0 != 64) begin
      fails++;
      $display("FAIL pwm_duty40 got %0d exp 64", on0);
    end
    tests++;
    if (on1 != 256) begin
      fails++;
      $display("FAIL pwm_full got %0d exp 256", on1);
    end
    bus_write(BASE + 32'h20, 32'h000);
    repeat (2) @(posedge clk);
    on0 = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk);
      #1;
      if (ledr[0] !== 1'b0) on0++;
    end
    tests++;
    if (on0 != 0) begin
      fails++;
      $display("FAIL pwm_duty0 got %0d exp 0", on0);
    end
  endtask

  task automatic test_unused();
    logic [31:0] d;
    logic ak;
    bus_write(BASE + 32'h00, 32'h155);
    bus_write(BASE + 32'h48, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h48, d, ak);
    tests++;
    if (d !== 32'h0 || ak !== 1'b1) begin
      fails++;
      $display("FAIL duty_oob got %h/%b exp 0/1", d, ak);
    end
    bus_read(BASE + 32'h1C, d, ak);
    tests++;
    if (d !== 32'h0 || ak !== 1'b1) begin
      fails++;
      $display("FAIL gap_rd got %h/%b exp 0/1", d, ak);
    end
    bus_read(BASE + 32'h00, d, ak);
    tests++;
    if (d !== 32'h155) begin
      fails++;
      $display("FAIL oob_wr_ignored got %h exp 155", d);
    end
    bus_read(BASE + 32'h1000, d, ak);
    tests++;
    if (ak === 1'b1) begin
      fails++;
      $display("FAIL nocs_ack got %b exp z", ak);
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [31:0] d;
    logic ak;
    bus_write(BASE + 32'h10, 32'h3FF);
    bus_write(BASE + 32'h14, 32'd4);
    bus_write(BASE + 32'h00, 32'h3FF);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (ledr !== 10'h000) begin
      fails++;
      $display("FAIL midrst_ledr got %h exp 000", ledr);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(BASE + 32'h00, d, ak);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL midrst_out got %h exp 0", d);
    end
    bus_read(BASE + 32'h10, d, ak);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL midrst_mode got %h exp 0", d);
    end
    bus_read(BASE + 32'h14, d, ak);
    tests++;
    if (d !== 32'd12_500_000) begin
      fails++;
      $display("FAIL midrst_blink got %0d exp 12500000", d);
    end
    bus_read(BASE + 32'h18, d, ak);
    tests++;
    if (d[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_phase got %b exp 1", d[0]);
    end
  endtask

  initial begin
    test_reset();
    test_static_on();
    test_set_clr_tgl();
    test_read_write_same();
    test_blink();
    test_pwm();
    test_unused();
    test_reset_mid_blink();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
